decode_stage_hz: RTL and testbench

//  Parametrised RV32I decode stage with an integrated ID/EX pipeline register, register file, and writeback-to-decode bypass.

---
 rtl/decode_stage_hz_if.sv | 47 ++++
 rtl/decode_stage_hz.sv | 186 ++++++++++++++++++
 tb/tb_decode_stage_hz.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_hz_if.sv
// Decode-to-execute bundle: fetch inputs, writeback port and ID/EX outputs.
interface decode_stage_hz_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [31:0]     InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic            ValidD;
  logic            StallE;
  logic            FlushE;
  logic            RegWriteW;
  logic [AW-1:0]   RDW;
  logic [XLEN-1:0] ResultW;
  logic            RegWriteE;
  logic            ALUSrcE;
  logic            MemWriteE;
  logic            ResultSrcE;
  logic            BranchE;
  logic [2:0]      ALUControlE;
  logic [XLEN-1:0] RD1_E;
  logic [XLEN-1:0] RD2_E;
  logic [XLEN-1:0] Imm_Ext_E;
  logic [AW-1:0]   RD_E;
  logic [AW-1:0]   RS1_E;
  logic [AW-1:0]   RS2_E;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;
  logic            ValidE;
  logic            IllegalE;

  modport master (
    output InstrD, PCD, PCPlus4D, ValidD, StallE, FlushE,
    output RegWriteW, RDW, ResultW,
    input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE,
    input  ALUControlE, RD1_E, RD2_E, Imm_Ext_E, RD_E, RS1_E, RS2_E,
    input  PCE, PCPlus4E, ValidE, IllegalE
  );

  modport slave (
    input  InstrD, PCD, PCPlus4D, ValidD, StallE, FlushE,
    input  RegWriteW, RDW, ResultW,
    output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE,
    output ALUControlE, RD1_E, RD2_E, Imm_Ext_E, RD_E, RS1_E, RS2_E,
    output PCE, PCPlus4E, ValidE, IllegalE
  );
endinterface

// File: rtl/decode_stage_hz.sv
// RV32I decode stage: register file with WB bypass, decoders, ID/EX register.
module decode_stage_hz #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input logic clk,
  input logic rst,
  decode_stage_hz_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  typedef struct packed {
    logic            reg_write;
    logic            alu_src;
    logic            mem_write;
    logic            result_src;
    logic            branch;
    logic [2:0]      alu_ctrl;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [AW-1:0]   rd;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic            valid;
    logic            illegal;
  } id_ex_t;

  logic [XLEN-1:0] rf [NREGS];
  logic [31:0]     ins;
  logic [6:0]      op;
  logic [2:0]      f3;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [AW-1:0]   rd;
  logic            wr_ok;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;

  assign ins   = bus.InstrD;
  assign op    = ins[6:0];
  assign f3    = ins[14:12];
  assign rs1   = AW'(ins[19:15]);
  assign rs2   = AW'(ins[24:20]);
  assign rd    = AW'(ins[11:7]);
  assign wr_ok = bus.RegWriteW && (bus.RDW != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) rf[k] <= '0;
    end else if (wr_ok) begin
      rf[bus.RDW] <= bus.ResultW;
    end
  end

  always_comb begin
    rd1 = rf[rs1];
    rd2 = rf[rs2];
    if (BYPASS != 0 && wr_ok && bus.RDW == rs1) rd1 = bus.ResultW;
    if (BYPASS != 0 && wr_ok && bus.RDW == rs2) rd2 = bus.ResultW;
    if (rs1 == '0) rd1 = '0;
    if (rs2 == '0) rd2 = '0;
  end

  logic            is_lw, is_sw, is_r, is_i, is_beq;
  logic            c_rw, c_as, c_mw, c_rs, c_br, c_ill;
  logic [1:0]      alu_op;
  logic [2:0]      alu_ctrl;
  logic [XLEN-1:0] imm;

  assign is_lw  = (op == 7'b0000011);
  assign is_sw  = (op == 7'b0100011);
  assign is_r   = (op == 7'b0110011);
  assign is_i   = (op == 7'b0010011);
  assign is_beq = (op == 7'b1100011);

  always_comb begin
    c_rw   = 1'b0;
    c_as   = 1'b0;
    c_mw   = 1'b0;
    c_rs   = 1'b0;
    c_br   = 1'b0;
    c_ill  = 1'b0;
    alu_op = 2'b00;
    imm    = '0;
    unique case (1'b1)
      is_lw: begin
        c_rw = 1'b1;
        c_as = 1'b1;
        c_rs = 1'b1;
        imm  = {{(XLEN-12){ins[31]}}, ins[31:20]};
      end
      is_sw: begin
        c_mw = 1'b1;
        c_as = 1'b1;
        imm  = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
      end
      is_r: begin
        c_rw   = 1'b1;
        alu_op = 2'b10;
      end
      is_i: begin
        c_rw   = 1'b1;
        c_as   = 1'b1;
        alu_op = 2'b10;
        imm    = {{(XLEN-12){ins[31]}}, ins[31:20]};
      end
      is_beq: begin
        c_br   = 1'b1;
        alu_op = 2'b01;
        imm    = {{(XLEN-13){ins[31]}}, ins[31], ins[7],
                  ins[30:25], ins[11:8], 1'b0};
      end
      default: c_ill = 1'b1;
    endcase
  end

  // funct7[5] only selects sub for register-register ops
  always_comb begin
    alu_ctrl = 3'b000;
    unique case (alu_op)
      2'b01: alu_ctrl = 3'b001;
      2'b10: begin
        case (f3)
          3'b000:  alu_ctrl = (op[5] & ins[30]) ? 3'b001 : 3'b000;
          3'b010:  alu_ctrl = 3'b101;
          3'b110:  alu_ctrl = 3'b011;
          3'b111:  alu_ctrl = 3'b010;
          default: alu_ctrl = 3'b000;
        endcase
      end
      default: alu_ctrl = 3'b000;
    endcase
  end

  id_ex_t nxt;
  id_ex_t q;

  always_comb begin
    nxt = '0;
    if (bus.ValidD) begin
      nxt.valid      = 1'b1;
      nxt.illegal    = c_ill;
      nxt.reg_write  = c_rw;
      nxt.alu_src    = c_as;
      nxt.mem_write  = c_mw;
      nxt.result_src = c_rs;
      nxt.branch     = c_br;
      nxt.alu_ctrl   = c_ill ? 3'b000 : alu_ctrl;
      nxt.imm        = imm;
      nxt.rd1        = rd1;
      nxt.rd2        = rd2;
      nxt.rd         = rd;
      nxt.rs1        = rs1;
      nxt.rs2        = rs2;
      nxt.pc         = bus.PCD;
      nxt.pc4        = bus.PCPlus4D;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)              q <= '0;
    else if (bus.FlushE)  q <= '0;
    else if (!bus.StallE) q <= nxt;
  end

  assign bus.RegWriteE   = q.reg_write;
  assign bus.ALUSrcE     = q.alu_src;
  assign bus.MemWriteE   = q.mem_write;
  assign bus.ResultSrcE  = q.result_src;
  assign bus.BranchE     = q.branch;
  assign bus.ALUControlE = q.alu_ctrl;
  assign bus.RD1_E       = q.rd1;
  assign bus.RD2_E       = q.rd2;
  assign bus.Imm_Ext_E   = q.imm;
  assign bus.RD_E        = q.rd;
  assign bus.RS1_E       = q.rs1;
  assign bus.RS2_E       = q.rs2;
  assign bus.PCE         = q.pc;
  assign bus.PCPlus4E    = q.pc4;
  assign bus.ValidE      = q.valid;
  assign bus.IllegalE    = q.illegal;
endmodule

// File: tb/tb_decode_stage_hz.sv
// Scoreboard bench for decode_stage_hz: reference decode and register model.
module tb_decode_stage_hz;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_stage_hz_if #(.XLEN(32), .AW(5)) bus ();

  decode_stage_hz #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [31:0] rw, as, mw, rs, br, alu;
    logic [31:0] rd1, rd2, imm, rd, rs1, rs2;
    logic [31:0] pc, pc4, v, ill;
  } exp_t;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] rf_m [32];
  exp_t cur;
  exp_t sb [$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  function automatic exp_t zero_e();
    exp_t e;
    e.rw = 0; e.as = 0; e.mw = 0; e.rs = 0; e.br = 0; e.alu = 0;
    e.rd1 = 0; e.rd2 = 0; e.imm = 0; e.rd = 0; e.rs1 = 0; e.rs2 = 0;
    e.pc = 0; e.pc4 = 0; e.v = 0; e.ill = 0;
    return e;
  endfunction

  function automatic logic [31:0] alu_of(logic [31:0] i, logic r);
    case (i[14:12])
      3'd0:    return (r && i[30]) ? 32'd1 : 32'd0;
      3'd2:    return 32'd5;
      3'd6:    return 32'd3;
      3'd7:    return 32'd2;
      default: return 32'd0;
    endcase
  endfunction

  function automatic exp_t dec(logic [31:0] i, logic [31:0] pc, logic v,
                               logic [31:0] a, logic [31:0] b);
    exp_t e = zero_e();
    logic [31:0] ii = {{20{i[31]}}, i[31:20]};
    if (!v) return e;
    e.v = 1; e.pc = pc; e.pc4 = pc + 4; e.rd1 = a; e.rd2 = b;
    e.rd = 32'(i[11:7]); e.rs1 = 32'(i[19:15]); e.rs2 = 32'(i[24:20]);
    case (i[6:0])
      7'h03: begin e.rw = 1; e.as = 1; e.rs = 1; e.imm = ii; end
      7'h23: begin
        e.mw = 1; e.as = 1;
        e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
      end
      7'h33: begin e.rw = 1; e.alu = alu_of(i, 1'b1); end
      7'h13: begin e.rw = 1; e.as = 1; e.imm = ii; e.alu = alu_of(i, 1'b0); end
      7'h63: begin
        e.br = 1; e.alu = 1;
        e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rd_m(logic [4:0] a, logic we,
                                      logic [4:0] w, logic [31:0] d);
    if (a == 0) return 0;
    if (we && w == a) return d;
    return rf_m[a];
  endfunction

  task automatic compare(input exp_t e);
    check("RegWriteE",   32'(bus.RegWriteE),   e.rw);
    check("ALUSrcE",     32'(bus.ALUSrcE),     e.as);
    check("MemWriteE",   32'(bus.MemWriteE),   e.mw);
    check("ResultSrcE",  32'(bus.ResultSrcE),  e.rs);
    check("BranchE",     32'(bus.BranchE),     e.br);
    check("ALUControlE", 32'(bus.ALUControlE), e.alu);
    check("RD1_E",       bus.RD1_E,            e.rd1);
    check("RD2_E",       bus.RD2_E,            e.rd2);
    check("Imm_Ext_E",   bus.Imm_Ext_E,        e.imm);
    check("RD_E",        32'(bus.RD_E),        e.rd);
    check("RS1_E",       32'(bus.RS1_E),       e.rs1);
    check("RS2_E",       32'(bus.RS2_E),       e.rs2);
    check("PCE",         bus.PCE,              e.pc);
    check("PCPlus4E",    bus.PCPlus4E,         e.pc4);
    check("ValidE",      32'(bus.ValidE),      e.v);
    check("IllegalE",    32'(bus.IllegalE),    e.ill);
  endtask

  task automatic step(input logic [31:0] ins, input logic [31:0] pc,
                      input logic v, input logic st, input logic fl,
                      input logic r, input logic we, input logic [4:0] w,
                      input logic [31:0] d);
    logic [31:0] a, b;
    bus.InstrD = ins; bus.PCD = pc; bus.PCPlus4D = pc + 4;
    bus.ValidD = v; bus.StallE = st; bus.FlushE = fl; rst = r;
    bus.RegWriteW = we; bus.RDW = w; bus.ResultW = d;
    a = rd_m(ins[19:15], we, w, d);
    b = rd_m(ins[24:20], we, w, d);
    if (r || fl) cur = zero_e();
    else if (!st) cur = dec(ins, pc, v, a, b);
    if (r) begin
      for (int k = 0; k < 32; k++) rf_m[k] = 0;
    end else if (we && w != 0) begin
      rf_m[w] = d;
    end
    sb.push_back(cur);
    @(posedge clk);
    #1;
    compare(sb.pop_front());
  endtask

  task automatic go(input logic [31:0] ins, input logic [31:0] pc);
    step(ins, pc, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  logic [6:0] ops [7] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h7F, 7'h00};

  initial begin
    cur = zero_e();
    for (int k = 0; k < 32; k++) rf_m[k] = 0;
    bus.InstrD = 0; bus.PCD = 0; bus.PCPlus4D = 0; bus.ValidD = 0;
    bus.StallE = 0; bus.FlushE = 0; bus.RegWriteW = 0; bus.RDW = 0;
    bus.ResultW = 0;

    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h10);
    go(32'h00402283, 32'h100);
    check("lw_imm", bus.Imm_Ext_E, 32'd4);
    check("lw_rd", 32'(bus.RD_E), 32'd5);

    step(32'h002081B3, 32'h104, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1,
         32'hDEADBEEF);
    check("byp_rd1", bus.RD1_E, 32'hDEADBEEF);
    check("add_rd2", bus.RD2_E, 32'h10);

    go(32'hFE000EE3, 32'h108);
    check("beq_imm", bus.Imm_Ext_E, 32'hFFFFFFFC);
    check("beq_alu", 32'(bus.ALUControlE), 32'd1);
    go(32'h00612423, 32'h10C);
    check("sw_imm", bus.Imm_Ext_E, 32'd8);
    check("sw_mw", 32'(bus.MemWriteE), 32'd1);

    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h55);
    go(32'h000001B3, 32'h110);
    check("x0_rd1", bus.RD1_E, 32'd0);
    go(32'h0000007F, 32'h114);
    check("ill", 32'(bus.IllegalE), 32'd1);

    go(32'h40208233, 32'h118);
    check("sub_alu", 32'(bus.ALUControlE), 32'd1);
    go(32'h40008213, 32'h11C);
    check("addi_alu", 32'(bus.ALUControlE), 32'd0);
    go(32'h0020A2B3, 32'h120);
    go(32'h0010E293, 32'h124);
    go(32'h0020F2B3, 32'h128);
    go(32'h0020C2B3, 32'h12C);

    go(32'h00402283, 32'h130);
    step(32'h002081B3, 32'h134, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 32'h11);
    step(32'hFE000EE3, 32'h138, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 32'h22);
    step(32'h00612423, 32'h13C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    check("stall_pc", bus.PCE, 32'h130);
    go(32'h002081B3, 32'h140);
    check("post_rd2", bus.RD2_E, 32'h22);
    step(32'h00612423, 32'h144, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    check("sf_valid", 32'(bus.ValidE), 32'd0);

    for (int n = 0; n < 80; n++) begin
      logic [31:0] r, p;
      r = $urandom();
      p = $urandom();
      step({r[31:7], ops[$urandom_range(0, 6)]}, p, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
           1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           $urandom());
    end

    go(32'h002081B3, 32'h200);
    step(32'h002081B3, 32'h204, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    go(32'h002081B3, 32'h208);
    check("rst_rf", bus.RD1_E, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
